// File: rtl/spi_xfer_sequencer_if.sv
// Client command/response handshake plus the Wishbone master bus of the SPI transfer sequencer.
// The master modport is the sequencer's view; the slave modport is the client/SPI-core side.
interface spi_xfer_sequencer_if;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic [31:0] cmd_data_i;
  logic [4:0]  cmd_len_i;
  logic [4:0]  cmd_ss_i;
  logic [2:0]  cmd_mode_i;
  logic [31:0] cfg_divider_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_data_o;
  logic        rsp_err_o;
  logic        busy_o;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [4:0]  wbm_adr_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_dat_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;
  logic        wbm_err_i;

  modport master (
    input  cmd_valid_i, cmd_data_i, cmd_len_i, cmd_ss_i, cmd_mode_i, cfg_divider_i,
    input  rsp_ready_i, wbm_dat_i, wbm_ack_i, wbm_err_i,
    output cmd_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o, busy_o,
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_sel_o, wbm_dat_o
  );

  modport slave (
    output cmd_valid_i, cmd_data_i, cmd_len_i, cmd_ss_i, cmd_mode_i, cfg_divider_i,
    output rsp_ready_i, wbm_dat_i, wbm_ack_i, wbm_err_i,
    input  cmd_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o, busy_o,
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_sel_o, wbm_dat_o
  );
endinterface

// File: rtl/spi_xfer_sequencer.sv
// Runs one SPI character per client command by programming the SPI core's Wishbone
// registers (DIVIDE, SS, TX0, CTRL), polling GO and returning the masked RX0 value.
module spi_xfer_sequencer #(
  parameter int unsigned POLL_GAP = 4,
  parameter int unsigned POLL_MAX = 1024
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_n_i,
  spi_xfer_sequencer_if.master bus
);

  // state  | meaning
  // IDLE   | waiting for a command
  // WR_DIV | write DIVIDE (only when the shadow is invalid or stale)
  // WR_SS  | write SS with the one-hot slave select
  // WR_TX  | write TX0 with the tx character
  // WR_CFG | write CTRL with GO clear
  // WR_GO  | write CTRL with GO set
  // POLL   | read CTRL, wait for GO to clear
  // GAP    | idle cycles between polls
  // RD_RX  | read RX0
  // RESP   | response held until the client takes it
  typedef enum logic [3:0] {
    IDLE, WR_DIV, WR_SS, WR_TX, WR_CFG, WR_GO, POLL, GAP, RD_RX, RESP
  } state_t;

  localparam logic [4:0] ADR_DATA = 5'h00;
  localparam logic [4:0] ADR_CTRL = 5'h10;
  localparam logic [4:0] ADR_DIV  = 5'h14;
  localparam logic [4:0] ADR_SS   = 5'h18;

  localparam int unsigned GAP_W  = (POLL_GAP > 2) ? $clog2(POLL_GAP) : 1;
  localparam int unsigned POLL_W = (POLL_MAX > 1) ? $clog2(POLL_MAX) : 1;
  localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'((POLL_GAP > 1) ? POLL_GAP - 2 : 0);
  localparam logic [POLL_W-1:0] POLL_LOAD = POLL_W'(POLL_MAX - 1);

  state_t              state_q;
  logic                acc_on_q;
  logic [31:0]         cmd_data_q;
  logic [4:0]          cmd_len_q;
  logic [4:0]          cmd_ss_q;
  logic [2:0]          cmd_mode_q;
  logic [31:0]         div_q;
  logic [31:0]         div_shadow_q;
  logic                div_valid_q;
  logic [POLL_W-1:0]   poll_left_q;
  logic [GAP_W-1:0]    gap_cnt_q;
  logic                cmd_ready_q;
  logic                busy_q;
  logic                rsp_valid_q;
  logic [31:0]         rsp_data_q;
  logic                rsp_err_q;
  logic                cyc_q;
  logic                stb_q;
  logic                we_q;
  logic [4:0]          adr_q;
  logic [3:0]          sel_q;
  logic [31:0]         dat_q;

  logic [4:0]          acc_adr_d;
  logic [31:0]         acc_dat_d;
  logic                acc_we_d;
  logic [31:0]         cfg_word;
  logic [31:0]         rx_mask;
  logic                need_div;

  // CTRL layout: ass=1 at bit13, ie=0, {lsb,tx_neg,rx_neg} at bits 11:9, go at bit8, len at 4:0
  assign cfg_word = {18'b0, 1'b1, 1'b0, cmd_mode_q, 1'b0, 3'b0, cmd_len_q};
  assign rx_mask  = (cmd_len_q == 5'd0) ? 32'hFFFF_FFFF : ((32'd1 << cmd_len_q) - 32'd1);
  assign need_div = !div_valid_q || (div_shadow_q != bus.cfg_divider_i);

  always_comb begin
    acc_adr_d = ADR_DATA;
    acc_dat_d = 32'h0;
    acc_we_d  = 1'b1;
    case (state_q)
      WR_DIV: begin acc_adr_d = ADR_DIV;  acc_dat_d = div_q;               end
      WR_SS:  begin acc_adr_d = ADR_SS;   acc_dat_d = 32'd1 << cmd_ss_q;   end
      WR_TX:  begin acc_adr_d = ADR_DATA; acc_dat_d = cmd_data_q;          end
      WR_CFG: begin acc_adr_d = ADR_CTRL; acc_dat_d = cfg_word;            end
      WR_GO:  begin acc_adr_d = ADR_CTRL; acc_dat_d = cfg_word | 32'h100;  end
      POLL:   begin acc_adr_d = ADR_CTRL; acc_we_d  = 1'b0;                end
      RD_RX:  begin acc_adr_d = ADR_DATA; acc_we_d  = 1'b0;                end
      default: ;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q      <= IDLE;
      acc_on_q     <= 1'b0;
      cmd_data_q   <= '0;
      cmd_len_q    <= '0;
      cmd_ss_q     <= '0;
      cmd_mode_q   <= '0;
      div_q        <= '0;
      div_shadow_q <= '0;
      div_valid_q  <= 1'b0;
      poll_left_q  <= '0;
      gap_cnt_q    <= '0;
      cmd_ready_q  <= 1'b0;
      busy_q       <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
      cyc_q        <= 1'b0;
      stb_q        <= 1'b0;
      we_q         <= 1'b0;
      adr_q        <= '0;
      sel_q        <= '0;
      dat_q        <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.cmd_valid_i && cmd_ready_q) begin
            cmd_data_q  <= bus.cmd_data_i;
            cmd_len_q   <= bus.cmd_len_i;
            cmd_ss_q    <= bus.cmd_ss_i;
            cmd_mode_q  <= bus.cmd_mode_i;
            div_q       <= bus.cfg_divider_i;
            poll_left_q <= POLL_LOAD;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= need_div ? WR_DIV : WR_SS;
          end else begin
            cmd_ready_q <= 1'b1;
          end
        end
        GAP: begin
          if (gap_cnt_q == '0) state_q <= POLL;
          else                 gap_cnt_q <= gap_cnt_q - 1'b1;
        end
        RESP: begin
          if (bus.rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          // The first cycle of every access state keeps the bus idle, giving the gap after each ack.
          if (!acc_on_q) begin
            acc_on_q <= 1'b1;
            cyc_q    <= 1'b1;
            stb_q    <= 1'b1;
            we_q     <= acc_we_d;
            adr_q    <= acc_adr_d;
            sel_q    <= 4'hF;
            dat_q    <= acc_dat_d;
          end else if (bus.wbm_err_i || bus.wbm_ack_i) begin
            acc_on_q <= 1'b0;
            cyc_q    <= 1'b0;
            stb_q    <= 1'b0;
            we_q     <= 1'b0;
            adr_q    <= '0;
            sel_q    <= '0;
            dat_q    <= '0;
            if (bus.wbm_err_i) begin
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_data_q  <= '0;
              state_q     <= RESP;
            end else begin
              case (state_q)
                WR_DIV: begin
                  div_shadow_q <= div_q;
                  div_valid_q  <= 1'b1;
                  state_q      <= WR_SS;
                end
                WR_SS:  state_q <= WR_TX;
                WR_TX:  state_q <= WR_CFG;
                WR_CFG: state_q <= WR_GO;
                WR_GO:  state_q <= POLL;
                POLL: begin
                  if (!bus.wbm_dat_i[8]) begin
                    state_q <= RD_RX;
                  end else if (poll_left_q == '0) begin
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= 1'b1;
                    rsp_data_q  <= '0;
                    state_q     <= RESP;
                  end else begin
                    poll_left_q <= poll_left_q - 1'b1;
                    gap_cnt_q   <= GAP_LOAD;
                    state_q     <= (POLL_GAP <= 1) ? POLL : GAP;
                  end
                end
                RD_RX: begin
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= 1'b0;
                  rsp_data_q  <= bus.wbm_dat_i & rx_mask;
                  state_q     <= RESP;
                end
                default: state_q <= IDLE;
              endcase
            end
          end
        end
      endcase
    end
  end

  assign bus.cmd_ready_o = cmd_ready_q;
  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.rsp_data_o  = rsp_data_q;
  assign bus.rsp_err_o   = rsp_err_q;
  assign bus.busy_o      = busy_q;
  assign bus.wbm_cyc_o   = cyc_q;
  assign bus.wbm_stb_o   = stb_q;
  assign bus.wbm_we_o    = we_q;
  assign bus.wbm_adr_o   = adr_q;
  assign bus.wbm_sel_o   = sel_q;
  assign bus.wbm_dat_o   = dat_q;

endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// Directed bench for spi_xfer_sequencer against a behavioural zero-wait SPI-core register slave,
// with bus-write and response scoreboards.
module tb_spi_xfer_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  spi_xfer_sequencer_if ifc();
  spi_xfer_sequencer #(.POLL_GAP(4), .POLL_MAX(4)) dut (
    .wb_clk_i  (clk),
    .wb_rst_n_i(rst_n),
    .bus       (ifc)
  );

  typedef struct packed { logic [4:0] adr; logic [31:0] dat; } wr_t;
  typedef struct packed { logic [31:0] data; logic err; } rsp_t;
  wr_t  exp_wr[$];
  rsp_t exp_rsp[$];

  int checks = 0;
  int errors = 0;
  int n_ctrl_wr = 0;
  int n_go_reads = 0;

  // slave model knobs and state
  int          go_polls = 0;
  bit          never_clear = 0;
  bit          rx_ovr_en = 0;
  logic [31:0] rx_ovr = '0;
  bit          err_en = 0;
  logic [4:0]  err_adr = '0;
  logic [31:0] s_tx = '0;
  logic [31:0] s_ctrl = '0;
  int          s_go_left = 0;
  logic        s_ack, s_err, s_go;

  always_comb s_go = never_clear ? s_ctrl[8] : (s_go_left != 0);
  always_comb begin
    ifc.wbm_dat_i = 32'h0;
    if (ifc.wbm_adr_o == 5'h10)      ifc.wbm_dat_i = {s_ctrl[31:9], s_go, s_ctrl[7:0]};
    else if (ifc.wbm_adr_o == 5'h00) ifc.wbm_dat_i = rx_ovr_en ? rx_ovr : s_tx;
  end
  assign ifc.wbm_ack_i = s_ack;
  assign ifc.wbm_err_i = s_err;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_ack <= 1'b0;
      s_err <= 1'b0;
    end else begin
      s_ack <= 1'b0;
      s_err <= 1'b0;
      if (s_ack && !ifc.wbm_we_o && ifc.wbm_adr_o == 5'h10 && s_go_left > 0)
        s_go_left <= s_go_left - 1;
      if (ifc.wbm_cyc_o && ifc.wbm_stb_o && !s_ack && !s_err) begin
        if (err_en && ifc.wbm_we_o && ifc.wbm_adr_o == err_adr) begin
          s_err <= 1'b1;
        end else begin
          s_ack <= 1'b1;
          if (ifc.wbm_we_o) begin
            if (ifc.wbm_adr_o == 5'h00) s_tx <= ifc.wbm_dat_o;
            if (ifc.wbm_adr_o == 5'h10) begin
              s_ctrl <= ifc.wbm_dat_o;
              if (ifc.wbm_dat_o[8]) s_go_left <= go_polls;
            end
          end
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic wr_t mk_wr(input logic [4:0] a, input logic [31:0] d);
    wr_t w;
    w.adr = a;
    w.dat = d;
    return w;
  endfunction

  // Bus-write scoreboard: every acked write must match the next expected write in order.
  always @(negedge clk) begin
    if (ifc.wbm_cyc_o && ifc.wbm_stb_o && ifc.wbm_ack_i) begin
      if (ifc.wbm_we_o) begin
        wr_t e;
        if (ifc.wbm_adr_o == 5'h10) n_ctrl_wr++;
        check("wr_expected", 32'(exp_wr.size() != 0), 32'd1);
        if (exp_wr.size() != 0) begin
          e = exp_wr.pop_front();
          check("wr_adr", 32'(ifc.wbm_adr_o), 32'(e.adr));
          check("wr_dat", ifc.wbm_dat_o, e.dat);
          check("wr_sel", 32'(ifc.wbm_sel_o), 32'hF);
        end
      end else if (ifc.wbm_adr_o == 5'h10 && ifc.wbm_dat_i[8]) begin
        n_go_reads++;
      end
    end
  end

  task automatic issue_cmd(input logic [31:0] d, input logic [4:0] l, input logic [4:0] s,
                           input logic [2:0] m, input logic [31:0] div, input bit exp_div,
                           input int n_wr, input logic [31:0] rdata, input logic rerr);
    wr_t seq[$];
    rsp_t r;
    logic [31:0] cfg;
    int lim;
    int n = 0;
    cfg = 32'h0000_2000 | ({29'b0, m} << 9) | {27'b0, l};
    if (exp_div) seq.push_back(mk_wr(5'h14, div));
    seq.push_back(mk_wr(5'h18, 32'h1 << s));
    seq.push_back(mk_wr(5'h00, d));
    seq.push_back(mk_wr(5'h10, cfg));
    seq.push_back(mk_wr(5'h10, cfg | 32'h100));
    lim = (n_wr < 0) ? seq.size() : n_wr;
    for (int i = 0; i < lim; i++) exp_wr.push_back(seq[i]);
    r.data = rdata;
    r.err  = rerr;
    exp_rsp.push_back(r);
    ifc.cmd_data_i    = d;
    ifc.cmd_len_i     = l;
    ifc.cmd_ss_i      = s;
    ifc.cmd_mode_i    = m;
    ifc.cfg_divider_i = div;
    ifc.cmd_valid_i   = 1'b1;
    while (!ifc.cmd_ready_o && n < 50) begin @(negedge clk); n++; end
    check("cmd_accept", 32'(ifc.cmd_ready_o), 32'd1);
    @(negedge clk);
    ifc.cmd_valid_i = 1'b0;
    check("busy_on", 32'(ifc.busy_o), 32'd1);
  endtask

  task automatic await_rsp(input int hold);
    rsp_t e;
    int n = 0;
    while (!ifc.rsp_valid_o && n < 2000) begin @(negedge clk); n++; end
    check("rsp_arrive", 32'(ifc.rsp_valid_o), 32'd1);
    check("rsp_queued", 32'(exp_rsp.size() != 0), 32'd1);
    if (exp_rsp.size() != 0) begin
      e = exp_rsp.pop_front();
      check("rsp_data", ifc.rsp_data_o, e.data);
      check("rsp_err", 32'(ifc.rsp_err_o), 32'(e.err));
      for (int i = 0; i < hold; i++) begin
        ifc.cmd_valid_i = 1'b1;
        @(negedge clk);
        check("hold_valid", 32'(ifc.rsp_valid_o), 32'd1);
        check("hold_data", ifc.rsp_data_o, e.data);
        check("hold_err", 32'(ifc.rsp_err_o), 32'(e.err));
        check("hold_cmd_ready", 32'(ifc.cmd_ready_o), 32'd0);
      end
    end
    ifc.cmd_valid_i = 1'b0;
    ifc.rsp_ready_i = 1'b1;
    @(negedge clk);
    ifc.rsp_ready_i = 1'b0;
    check("rsp_drop", 32'(ifc.rsp_valid_o), 32'd0);
    check("busy_off", 32'(ifc.busy_o), 32'd0);
  endtask

  initial begin
    ifc.cmd_valid_i   = 1'b0;
    ifc.cmd_data_i    = '0;
    ifc.cmd_len_i     = '0;
    ifc.cmd_ss_i      = '0;
    ifc.cmd_mode_i    = '0;
    ifc.cfg_divider_i = '0;
    ifc.rsp_ready_i   = 1'b0;

    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 32'(ifc.cmd_ready_o), 32'd0);
    check("rst_cyc", 32'(ifc.wbm_cyc_o), 32'd0);
    check("rst_stb", 32'(ifc.wbm_stb_o), 32'd0);
    check("rst_rsp_valid", 32'(ifc.rsp_valid_o), 32'd0);
    check("rst_busy", 32'(ifc.busy_o), 32'd0);
    check("rst_rsp_data", ifc.rsp_data_o, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_cmd_ready", 32'(ifc.cmd_ready_o), 32'd1);

    // basic loopback transfer, first divider write
    issue_cmd(32'hA5, 5'd8, 5'd2, 3'b000, 32'd1, 1'b1, -1, 32'hA5, 1'b0);
    await_rsp(0);
    // same divider: no DIVIDE write
    issue_cmd(32'hA5, 5'd8, 5'd2, 3'b000, 32'd1, 1'b0, -1, 32'hA5, 1'b0);
    await_rsp(0);
    // divider change
    issue_cmd(32'hA5, 5'd8, 5'd2, 3'b000, 32'd3, 1'b1, -1, 32'hA5, 1'b0);
    await_rsp(0);

    // 32-bit, lsb-first, GO stays set for two polls
    go_polls = 2;
    n_go_reads = 0;
    issue_cmd(32'hDEAD_BEEF, 5'd0, 5'd0, 3'b100, 32'd3, 1'b0, -1, 32'hDEAD_BEEF, 1'b0);
    await_rsp(0);
    check("go_reads_two", 32'(n_go_reads), 32'd2);
    go_polls = 0;

    // length mask
    rx_ovr_en = 1;
    rx_ovr = 32'hFF;
    issue_cmd(32'h5A, 5'd4, 5'd7, 3'b011, 32'd3, 1'b0, -1, 32'h0000_000F, 1'b0);
    await_rsp(0);
    rx_ovr_en = 0;

    // poll timeout
    never_clear = 1;
    n_go_reads = 0;
    issue_cmd(32'h12, 5'd8, 5'd1, 3'b000, 32'd3, 1'b0, -1, 32'h0, 1'b1);
    await_rsp(0);
    check("timeout_go_reads", 32'(n_go_reads), 32'd4);
    never_clear = 0;

    // bus error on the TX0 write, response held off for five cycles
    err_en = 1;
    err_adr = 5'h00;
    n_ctrl_wr = 0;
    issue_cmd(32'h77, 5'd8, 5'd3, 3'b000, 32'd3, 1'b0, 1, 32'h0, 1'b1);
    await_rsp(5);
    check("err_no_ctrl_wr", 32'(n_ctrl_wr), 32'd0);
    err_en = 0;

    // reset while a poll access is on the bus
    never_clear = 1;
    issue_cmd(32'h99, 5'd8, 5'd0, 3'b000, 32'd3, 1'b0, -1, 32'h0, 1'b1);
    begin
      int n = 0;
      while (!(ifc.wbm_cyc_o && ifc.wbm_stb_o && !ifc.wbm_we_o && ifc.wbm_adr_o == 5'h10) && n < 200) begin
        @(negedge clk);
        n++;
      end
      check("poll_seen", 32'(ifc.wbm_stb_o), 32'd1);
    end
    rst_n = 1'b0;
    #1;
    check("arst_cyc", 32'(ifc.wbm_cyc_o), 32'd0);
    check("arst_stb", 32'(ifc.wbm_stb_o), 32'd0);
    check("arst_busy", 32'(ifc.busy_o), 32'd0);
    check("arst_wr_done", 32'(exp_wr.size()), 32'd0);
    exp_rsp.delete();
    never_clear = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue_cmd(32'h3C, 5'd8, 5'd4, 3'b000, 32'd3, 1'b1, -1, 32'h3C, 1'b0);
    await_rsp(0);

    repeat (3) @(negedge clk);
    check("final_wr_empty", 32'(exp_wr.size()), 32'd0);
    check("final_idle_cyc", 32'(ifc.wbm_cyc_o), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/spi_xfer_sequencer.md
Name: spi_xfer_sequencer

Overview:
- Wishbone master that drives the SPI core's register slave, so a hardware client can run one SPI character per command without software.
- Accepts a command (tx data, length, slave index, mode) on a valid/ready handshake.
- Programs DIVIDE/SS/TX0/CTRL, sets GO, polls CTRL until GO clears, reads RX0, returns a masked response on a valid/ready handshake.
- Sits between the client logic and the SPI core's wb_* slave port; sole master of that port.

Parameters:
- POLL_GAP, 4, idle cycles between successive CTRL poll reads (0 allowed).
- POLL_MAX, 1024, number of CTRL polls seeing GO=1 before the transfer is declared timed out.

Ports:
- wb_clk_i  in  1  single clock
- wb_rst_n_i  in  1  reset, asynchronous, active-low
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  command accepted when valid&ready
- cmd_data_i  in  32  tx character, right-aligned
- cmd_len_i  in  5  char length; 0 means 32 bits
- cmd_ss_i  in  5  slave index, one-hot encoded into SS
- cmd_mode_i  in  3  {lsb, tx_negedge, rx_negedge}
- cfg_divider_i  in  32  sclk divider, quasi-static
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response consumed when valid&ready
- rsp_data_o  out  32  received character, masked to length
- rsp_err_o  out  1  bus error or poll timeout
- busy_o  out  1  high in any state other than IDLE
- wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1  Wishbone master controls
- wbm_adr_o  out  5  byte address; TX0/RX0=0x00, CTRL=0x10, DIVIDE=0x14, SS=0x18
- wbm_sel_o  out  4  always 4'hF during an access
- wbm_dat_o  out  32  write data
- wbm_dat_i  in  32  read data
- wbm_ack_i, wbm_err_i  in  1  cycle termination

Behaviour:
- Reset (async, wb_rst_n_i low):
  - All outputs 0; cmd_ready_o=0 during reset, 1 in IDLE afterwards.
  - State IDLE; divider shadow marked invalid.
  - Assertion mid-access drops cyc/stb immediately.
- Command capture: cmd_ready_o = (state==IDLE) & ~rsp_valid_o. On accept, latch all cmd_* and cfg_divider_i.
- States: IDLE -> [WR_DIV] -> WR_SS -> WR_TX -> WR_CFG -> WR_GO -> POLL -> (GAP -> POLL)* -> RD_RX -> RESP -> IDLE.
  - WR_DIV only if the shadow is invalid or differs from the latched divider; shadow updates on its ack.
- Register values written:
  - SS = 1 << cmd_ss.
  - TX0 = cmd_data.
  - CFG = {18'b0, ass=1, ie=0, lsb, tx_neg, rx_neg, go=0, 3'b0, len}.
  - GO = CFG | 0x100.
- Bus protocol, one access at a time:
  - cyc=stb=1 with adr/we/dat held stable until ack or err.
  - On the ack cycle, sample wbm_dat_i (reads).
  - Next cycle drive cyc=stb=0 for exactly 1 cycle before the next access; the slave's ack is a single-cycle toggle.
  - With the zero-wait core, each access is 3 cycles.
- POLL:
  - Read CTRL. If bit8==0, go to RD_RX.
  - Otherwise increment the poll counter and wait POLL_GAP cycles.
  - When the counter reaches POLL_MAX, go to RESP with err=1, data=0. The core transfer may still be running; the next command's writes are ignored by the core until tip falls. This is a client responsibility.
- RD_RX: read 0x00. rsp_data = rx & mask, mask = (len==0) ? 32'hFFFF_FFFF : (1<<len)-1.
- wbm_err_i during any access: drop cyc/stb, skip remaining accesses, go to RESP with err=1, data=0.
- RESP: rsp_valid_o=1 with stable data/err until rsp_ready_i, then IDLE. Same-cycle ready is allowed, giving 1 cycle in RESP.
- cmd_valid_i while busy is held off (ready=0). A cmd_valid_i in the same cycle as the rsp handshake is not accepted until the following IDLE cycle.
- Latency, zero-wait slave, divider unchanged, GO clearing on the first poll: accept to rsp_valid = 6 accesses x 3 = 18 cycles, +1 cycle into RESP.

Test Plan:
- Reset, then cmd len=8, data=0xA5, ss=2, mode=0, divider=1 (looped-back miso):
  - Bus sequence is DIV=1, SS=0x4, TX0=0xA5, CTRL=0x2008, CTRL=0x2108, polls, RX read.
  - rsp_data=0xA5, err=0.
- Second identical command: no DIVIDE write. Change divider to 3: exactly one DIVIDE write of 0x3 precedes SS.
- len=0, data=0xDEADBEEF, mode={lsb=1}: CTRL written 0x2800 then 0x2900; rsp_data=0xDEADBEEF. With len=4 and rx=0xFF, rsp_data=0xF.
- Slave model never clears GO, POLL_MAX=4: exactly 4 CTRL reads seeing GO=1, then rsp_err=1, rsp_data=0, busy_o falls.
- wbm_err_i asserted on the TX0 write: no CTRL writes issued, rsp_err=1. Hold rsp_ready_i=0 for 5 cycles: rsp stays stable, cmd_ready_o=0.
- Reset pulsed while stb high during POLL: cyc/stb fall asynchronously. The next command re-writes DIVIDE and completes normally.
